regfile_write_arbiter: RTL and testbench

Merges the processor writeback and a queued stream of game-input events (controller/player updates) onto the register file's single write port (`ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`). Sits directly upstream of `regfile`. Processor writeback always wins and is never delayed; events are buffered in a small FIFO and drained into otherwise-idle write cycles, typically targeting player registers 1–4.

---
 rtl/regwr_pkg.sv | 10 +
 rtl/regwr_fifo.sv | 48 ++++
 rtl/regfile_write_arbiter.sv | 83 ++++++++
 tb/tb_regfile_write_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/regwr_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regwr_pkg;
    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         DROPCNT_W = 8;

    typedef struct packed {
        logic [4:0]  wreg;
        logic [31:0] data;
    } regwr_evt_t;
endpackage

// File: rtl/regwr_fifo.sv
// Circular event buffer with push/pop, full/empty flags and an occupancy count.
module regwr_fifo
    import regwr_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  regwr_evt_t    din,
    output regwr_evt_t    head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    regwr_evt_t    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges CPU writeback (always wins) with queued game-input events onto one regfile write port.
// Optional drop counter enabled by defining REGWR_DROPCNT_EN.
module regfile_write_arbiter
    import regwr_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          ctrl_reset,
    input  logic          cpu_writeEnable,
    input  logic [4:0]    cpu_writeReg,
    input  logic [31:0]   cpu_data,
    input  logic          evt_valid,
    input  logic [4:0]    evt_reg,
    input  logic [31:0]   evt_data,
    output logic          evt_ready,
    output logic [CW-1:0] fifo_count,
    output logic          ctrl_writeEnable,
    output logic [4:0]    ctrl_writeReg,
    output logic [31:0]   data_writeReg,
    output logic          src_evt
`ifdef REGWR_DROPCNT_EN
    ,
    output logic [DROPCNT_W-1:0] drop_count
`endif
);
    logic       cpu_eff;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    regwr_evt_t head;
    regwr_evt_t din;

    assign cpu_eff = cpu_writeEnable && (cpu_writeReg != REG_ZERO);
    assign push    = !ctrl_reset && evt_valid && (evt_reg != REG_ZERO);
    // Events only drain into cycles the CPU leaves idle (including writes to r0).
    assign pop     = !ctrl_reset && !cpu_eff && !empty;
    assign din     = '{wreg: evt_reg, data: evt_data};

    regwr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (ctrl_reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign evt_ready = !full;

    always_comb begin
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = REG_ZERO;
        data_writeReg    = '0;
        src_evt          = 1'b0;
        if (!ctrl_reset) begin
            if (cpu_eff) begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = cpu_writeReg;
                data_writeReg    = cpu_data;
            end else if (!empty) begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = head.wreg;
                data_writeReg    = head.data;
                src_evt          = 1'b1;
            end
        end
    end

`ifdef REGWR_DROPCNT_EN
    always_ff @(posedge clock) begin
        if (ctrl_reset)
            drop_count <= '0;
        else if (push && full && !pop && (drop_count != '1))
            drop_count <= drop_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (DEPTH=4).
module tb_regfile_write_arbiter;
    import regwr_pkg::*;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        cpu_writeEnable;
    logic [4:0]  cpu_writeReg;
    logic [31:0] cpu_data;
    logic        evt_valid;
    logic [4:0]  evt_reg;
    logic [31:0] evt_data;
    logic        evt_ready;
    logic [2:0]  fifo_count;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        src_evt;
`ifdef REGWR_DROPCNT_EN
    logic [7:0]  drop_count;
`endif

    int errors = 0;
    int checks = 0;

    regfile_write_arbiter #(.DEPTH(4)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .cpu_writeEnable  (cpu_writeEnable),
        .cpu_writeReg     (cpu_writeReg),
        .cpu_data         (cpu_data),
        .evt_valid        (evt_valid),
        .evt_reg          (evt_reg),
        .evt_data         (evt_data),
        .evt_ready        (evt_ready),
        .fifo_count       (fifo_count),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .src_evt          (src_evt)
`ifdef REGWR_DROPCNT_EN
        ,
        .drop_count       (drop_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply inputs just after a rising edge, then let combinational outputs settle.
    task automatic drive(input logic cwe, input logic [4:0] creg, input logic [31:0] cdat,
                         input logic ev, input logic [4:0] ereg, input logic [31:0] edat);
        cpu_writeEnable = cwe;
        cpu_writeReg    = creg;
        cpu_data        = cdat;
        evt_valid       = ev;
        evt_reg         = ereg;
        evt_data        = edat;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [4:0] r,
                            input logic [31:0] d, input logic se);
        check({tag, ".we"},   32'(ctrl_writeEnable), 32'(we));
        check({tag, ".reg"},  32'(ctrl_writeReg),    32'(r));
        check({tag, ".data"}, data_writeReg,         d);
        check({tag, ".src"},  32'(src_evt),          32'(se));
    endtask

    initial begin
        ctrl_reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        tick();
        // Reset: outputs forced to zero even with a CPU write present.
        drive(1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 32'h0);
        check_wr("rst_out", 1'b0, 5'd0, 32'h0, 1'b0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(evt_ready), 32'd1);
`ifdef REGWR_DROPCNT_EN
        check("rst_drop", 32'(drop_count), 32'd0);
`endif
        tick();
        ctrl_reset = 1'b0;

        // Single event, CPU idle: no bypass, appears next cycle.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h11);
        check_wr("t1_nobypass", 1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check_wr("t1_drain", 1'b1, 5'd2, 32'h11, 1'b1);
        check("t1_count1", 32'(fifo_count), 32'd1);
        tick();
        check("t1_count0", 32'(fifo_count), 32'd0);
        check_wr("t1_idle", 1'b0, 5'd0, 32'h0, 1'b0);

        // CPU busy for 3 cycles while two events queue; then in-order drain.
        drive(1'b1, 5'd7, 32'hFF, 1'b1, 5'd1, 32'hA);
        check_wr("t2_cpu0", 1'b1, 5'd7, 32'hFF, 1'b0);
        tick();
        drive(1'b1, 5'd7, 32'hFF, 1'b1, 5'd3, 32'hB);
        check_wr("t2_cpu1", 1'b1, 5'd7, 32'hFF, 1'b0);
        check("t2_count1", 32'(fifo_count), 32'd1);
        tick();
        drive(1'b1, 5'd7, 32'hFF, 1'b0, 5'd0, 32'h0);
        check_wr("t2_cpu2", 1'b1, 5'd7, 32'hFF, 1'b0);
        check("t2_count2", 32'(fifo_count), 32'd2);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check_wr("t2_ev1", 1'b1, 5'd1, 32'hA, 1'b1);
        tick();
        check_wr("t2_ev2", 1'b1, 5'd3, 32'hB, 1'b1);
        tick();
        check_wr("t2_done", 1'b0, 5'd0, 32'h0, 1'b0);
        check("t2_count0", 32'(fifo_count), 32'd0);

        // CPU write to r0 is an idle slot for the queued event.
        drive(1'b1, 5'd7, 32'hFF, 1'b1, 5'd4, 32'h5);
        tick();
        drive(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'h0);
        check_wr("t3_r0slot", 1'b1, 5'd4, 32'h5, 1'b1);
        tick();
        check("t3_count0", 32'(fifo_count), 32'd0);

        // Fill with CPU busy, drop at full, then push-with-pop at full.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'd7, 32'hFF, 1'b1, 5'(i), 32'h20 + 32'(i));
            tick();
        end
        drive(1'b1, 5'd7, 32'hFF, 1'b1, 5'd5, 32'h25);
        check("t4_full_cnt", 32'(fifo_count), 32'd4);
        check("t4_ready0", 32'(evt_ready), 32'd0);
        tick();
        check("t4_after_drop", 32'(fifo_count), 32'd4);
`ifdef REGWR_DROPCNT_EN
        check("t4_drop1", 32'(drop_count), 32'd1);
`endif
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h26);
        check_wr("t4_pop1", 1'b1, 5'd1, 32'h21, 1'b1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("t4_pushpop_cnt", 32'(fifo_count), 32'd4);
        check("t4_ready_still0", 32'(evt_ready), 32'd0);
`ifdef REGWR_DROPCNT_EN
        check("t4_drop_still1", 32'(drop_count), 32'd1);
`endif
        check_wr("t4_pop2", 1'b1, 5'd2, 32'h22, 1'b1);
        tick();
        check_wr("t4_pop3", 1'b1, 5'd3, 32'h23, 1'b1);
        tick();
        check_wr("t4_pop4", 1'b1, 5'd4, 32'h24, 1'b1);
        tick();
        check_wr("t4_pop6", 1'b1, 5'd6, 32'h26, 1'b1);
        tick();
        check_wr("t4_empty", 1'b0, 5'd0, 32'h0, 1'b0);
        check("t4_ready1", 32'(evt_ready), 32'd1);

        // Event to r0 is discarded silently.
        drive(1'b1, 5'd7, 32'hFF, 1'b1, 5'd0, 32'h77);
        tick();
        check("t5_count", 32'(fifo_count), 32'd0);
`ifdef REGWR_DROPCNT_EN
        check("t5_drop", 32'(drop_count), 32'd1);
`endif

        // Reset with three queued events discards them.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 5'd7, 32'hFF, 1'b1, 5'(i + 8), 32'h30 + 32'(i));
            tick();
        end
        check("t6_queued", 32'(fifo_count), 32'd3);
        ctrl_reset = 1'b1;
        drive(1'b1, 5'd9, 32'h1234, 1'b1, 5'd2, 32'h55);
        check_wr("t6_rst_out", 1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        check("t6_rst_count", 32'(fifo_count), 32'd0);
        check("t6_rst_ready", 32'(evt_ready), 32'd1);
        check_wr("t6_rst_out2", 1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        ctrl_reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check_wr("t6_post0", 1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        check_wr("t6_post1", 1'b0, 5'd0, 32'h0, 1'b0);
        check("t6_post_count", 32'(fifo_count), 32'd0);
`ifdef REGWR_DROPCNT_EN
        check("t6_drop_clr", 32'(drop_count), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
